// File: rtl/stack_ctrl.sv
// Operand stack controller for the multicycle stack-machine datapath.
// Owns the stack storage and pointer and executes one push, pop or replace
// command per cycle. A push while full or a pop/replace while empty sets a
// sticky error flag and enters HALT. HALT blocks stack mutation until
// clr_err is asserted. The tos read strobe is still serviced in HALT.
module stack_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              tos,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] top,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow,
    output logic              halted,
    input  logic              clr_err
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   C_TWO   = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] C_I1    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_I2    = ADDR_W'(2);

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_count;
    logic [DATA_W-1:0] r_top;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              r_ovf;
    logic              r_udf;
    logic              r_halted;

    logic              w_empty;
    logic              w_full;
    logic              w_cmd_ok;
    logic              w_do_push;
    logic              w_do_repl;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_idx_cnt;
    logic [ADDR_W-1:0] w_idx_top;
    logic [ADDR_W-1:0] w_idx_below;
    logic [ADDR_W-1:0] w_wr_idx;
    logic [DATA_W-1:0] w_below;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_DEPTH);

    // Commands only act in RUN, and never in a reset or clear-error cycle.
    assign w_cmd_ok  = (r_state == ST_RUN) && !clr_err && !rst;
    assign w_do_push = w_cmd_ok && push && !pop && !w_full;
    assign w_do_repl = w_cmd_ok && push && pop && !w_empty;
    assign w_wr_en   = w_do_push || w_do_repl;

    // The low ADDR_W bits of count index the next free slot. When the stack
    // is full they wrap to 0, but a push is blocked in that case. The top
    // slot is count-1 and the entry beneath it is count-2.
    assign w_idx_cnt   = r_count[ADDR_W-1:0];
    assign w_idx_top   = w_idx_cnt - C_I1;
    assign w_idx_below = w_idx_cnt - C_I2;
    assign w_wr_idx    = w_do_repl ? w_idx_top : w_idx_cnt;
    assign w_below     = r_mem[w_idx_below];

    // Storage write port: a push appends at count, and a replace overwrites the top slot.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= din;
        end
    end

    // Control FSM: stack pointer, registered top, tos capture and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_count    <= '0;
            r_top      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            // tos captures the top value as it was before this edge's command.
            r_rd_valid <= tos;
            if (tos) begin
                r_rd_data <= r_top;
            end

            if (clr_err) begin
                r_ovf    <= 1'b0;
                r_udf    <= 1'b0;
                r_state  <= ST_RUN;
                r_halted <= 1'b0;
            end else if (r_state == ST_RUN) begin
                case ({push, pop})
                    2'b10: begin
                        if (!w_full) begin
                            r_count <= r_count + C_ONE;
                            r_top   <= din;
                        end else begin
                            r_ovf    <= 1'b1;
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end
                    2'b01: begin
                        if (!w_empty) begin
                            r_count <= r_count - C_ONE;
                            r_top   <= (r_count >= C_TWO) ? w_below : '0;
                        end else begin
                            r_udf    <= 1'b1;
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end
                    2'b11: begin
                        // A replace leaves depth unchanged, so it is legal on a full stack.
                        if (!w_empty) begin
                            r_top <= din;
                        end else begin
                            r_udf    <= 1'b1;
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign top       = r_top;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_udf;
    assign halted    = r_halted;

endmodule
